// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
// Defines the arbiter state, the port-grant encoding and the wait-counter width.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port, memory-side and stall signals around the arbiter.
// The slave modport is the arbiter; the master modport is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_f;
    logic              stall_m;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

endinterface

// File: rtl/mem_port_arbiter_counter.sv
// Wait-state counter: start clears it, then it counts up and parks at limit-1.
// done is high whenever the count sits on the last cycle of an access.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == (limit - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one fixed-latency unified memory,
// sequences each access through wait states and raises the pipeline stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              elig_i, elig_d;
    logic              start, done;

    // A req seen in the port's own ready cycle is stale and must not re-grant.
    assign elig_i = bus.if_req & ~if_ready_q;
    assign elig_d = bus.d_req  & ~d_ready_q;

    assign bus.stall_f   = elig_i;
    assign bus.stall_m   = elig_d;
    assign bus.mem_en    = (state_q == ST_BUSY);
    assign bus.mem_we    = (state_q == ST_BUSY) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;

    arb_wait_counter u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .limit (CNT_W'(WAIT_CYCLES)),
        .done  (done)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        start        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig_i || elig_d) begin
                    start   = 1'b1;
                    state_d = ST_BUSY;
                    // On a tie the port that was not served last wins.
                    if (elig_d && (!elig_i || (last_grant_q == GNT_I))) begin
                        grant_d      = GNT_D;
                        last_grant_d = GNT_D;
                        addr_d       = bus.d_addr;
                        we_d         = bus.d_we;
                        wdata_d      = bus.d_wdata;
                    end else begin
                        grant_d      = GNT_I;
                        last_grant_d = GNT_I;
                        addr_d       = bus.if_addr;
                        we_d         = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                    if (grant_q == GNT_I) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_I;
            last_grant_q <= GNT_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (WAIT_CYCLES=2) plus
// hand-written sequences on a second instance with WAIT_CYCLES=1.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic        rst_n, if_req, d_req, d_we, full;
        logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
        logic        e_en, e_we, e_ifrdy, e_drdy, e_sf, e_sm;
        logic [31:0] e_addr, e_wdata, e_ifrd, e_drd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] r, ifr, ia, dr, dw, da, dwd, mrd,
                       input logic [31:0] en, we, ea, ewd, ir, drr, ird, drd,
                       input logic [31:0] sf, sm, full);
        vec_t v;
        v.rst_n = r[0];   v.if_req = ifr[0]; v.if_addr = ia;  v.d_req = dr[0];
        v.d_we = dw[0];   v.d_addr = da;     v.d_wdata = dwd; v.mem_rdata = mrd;
        v.e_en = en[0];   v.e_we = we[0];    v.e_addr = ea;   v.e_wdata = ewd;
        v.e_ifrdy = ir[0]; v.e_drdy = drr[0]; v.e_ifrd = ird; v.e_drd = drd;
        v.e_sf = sf[0];   v.e_sm = sm[0];    v.full = full[0];
        vecs.push_back(v);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus1_drive(input logic ifr, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic [31:0] mrd);
        bus1.if_req = ifr; bus1.if_addr = ia; bus1.d_req = dr; bus1.d_we = 1'b0;
        bus1.d_addr = da;  bus1.d_wdata = '0; bus1.mem_rdata = mrd;
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_addr = '0;   bus0.d_wdata = '0; bus0.mem_rdata = '0;
        bus1_drive(1'b0, '0, 1'b0, '0, '0);

        // add(rst,if_req,if_addr,d_req,d_we,d_addr,d_wdata,mem_rdata, en,we,mem_addr,mem_wdata, if_rdy,d_rdy,if_rdata,d_rdata, stall_f,stall_m, full)
        add(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1);
        add(1,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1);
        // single fetch
        add(1,1,'h4,0,0,0,0,0,          0,0,0,0,   0,0,0,0,          1,0,0);
        add(1,1,'h4,0,0,0,0,0,          1,0,'h4,0, 0,0,0,0,          1,0,0);
        add(1,1,'h4,0,0,0,0,'h8C010000, 1,0,'h4,0, 0,0,0,0,          1,0,0);
        add(1,1,'h4,0,0,0,0,0,          0,0,0,0,   1,0,'h8C010000,0, 0,0,0);
        add(1,0,0,0,0,0,0,0,            0,0,0,0,   0,0,'h8C010000,0, 0,0,0);
        // reset clears captured read data and address
        add(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1);
        add(1,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1);
        // simultaneous requests after reset: D first, then I
        add(1,1,'h40,1,0,'h100,0,0,          0,0,0,0,      0,0,0,0,                   1,1,0);
        add(1,1,'h40,1,0,'h100,0,0,          1,0,'h100,0,  0,0,0,0,                   1,1,0);
        add(1,1,'h40,1,0,'h100,0,'h11111111, 1,0,'h100,0,  0,0,0,0,                   1,1,0);
        add(1,1,'h40,1,0,'h100,0,0,          0,0,0,0,      0,1,0,'h11111111,          1,0,0);
        add(1,1,'h40,0,0,0,0,0,              1,0,'h40,0,   0,0,0,'h11111111,          1,0,0);
        add(1,1,'h40,0,0,0,0,'h22222222,     1,0,'h40,0,   0,0,0,'h11111111,          1,0,0);
        add(1,1,'h40,0,0,0,0,0,              0,0,0,0,      1,0,'h22222222,'h11111111, 0,0,0);
        add(1,0,0,0,0,0,0,0,                 0,0,0,0,      0,0,'h22222222,'h11111111, 0,0,0);
        // both held for four accesses: D, I, D, I
        add(1,1,'h80,1,0,'h300,0,0,          0,0,0,0,     0,0,'h22222222,'h11111111, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,0,          1,0,'h300,0, 0,0,'h22222222,'h11111111, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,'hA0000001, 1,0,'h300,0, 0,0,'h22222222,'h11111111, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,0,          0,0,0,0,     0,1,'h22222222,'hA0000001, 1,0,0);
        add(1,1,'h80,1,0,'h300,0,0,          1,0,'h80,0,  0,0,'h22222222,'hA0000001, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,'hA0000002, 1,0,'h80,0,  0,0,'h22222222,'hA0000001, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,0,          0,0,0,0,     1,0,'hA0000002,'hA0000001, 0,1,0);
        add(1,1,'h80,1,0,'h300,0,0,          1,0,'h300,0, 0,0,'hA0000002,'hA0000001, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,'hA0000003, 1,0,'h300,0, 0,0,'hA0000002,'hA0000001, 1,1,0);
        add(1,1,'h80,1,0,'h300,0,0,          0,0,0,0,     0,1,'hA0000002,'hA0000003, 1,0,0);
        add(1,1,'h80,0,0,0,0,0,              1,0,'h80,0,  0,0,'hA0000002,'hA0000003, 1,0,0);
        add(1,1,'h80,0,0,0,0,'hA0000004,     1,0,'h80,0,  0,0,'hA0000002,'hA0000003, 1,0,0);
        add(1,1,'h80,0,0,0,0,0,              0,0,0,0,     1,0,'hA0000004,'hA0000003, 0,0,0);
        add(1,0,0,0,0,0,0,0,                 0,0,0,0,     0,0,'hA0000004,'hA0000003, 0,0,0);
        // store leaves d_rdata untouched
        add(1,0,0,1,1,'h200,'hDEADBEEF,0,          0,0,0,0,                 0,0,'hA0000004,'hA0000003, 0,1,0);
        add(1,0,0,1,1,'h200,'hDEADBEEF,0,          1,1,'h200,'hDEADBEEF,    0,0,'hA0000004,'hA0000003, 0,1,0);
        add(1,0,0,1,1,'h200,'hDEADBEEF,'h55555555, 1,1,'h200,'hDEADBEEF,    0,0,'hA0000004,'hA0000003, 0,1,0);
        add(1,0,0,1,1,'h200,'hDEADBEEF,0,          0,0,0,0,                 0,1,'hA0000004,'hA0000003, 0,0,0);
        add(1,0,0,0,0,0,0,0,                       0,0,0,0,                 0,0,'hA0000004,'hA0000003, 0,0,0);
        // reset in the middle of a load, then the held request completes
        add(1,0,0,1,0,'h104,0,0,          0,0,0,0,      0,0,'hA0000004,'hA0000003, 0,1,0);
        add(1,0,0,1,0,'h104,0,0,          1,0,'h104,0,  0,0,'hA0000004,'hA0000003, 0,1,0);
        add(0,0,0,1,0,'h104,0,0,          0,0,0,0,      0,0,0,0,                   0,1,1);
        add(1,0,0,1,0,'h104,0,0,          0,0,0,0,      0,0,0,0,                   0,1,1);
        add(1,0,0,1,0,'h104,0,0,          1,0,'h104,0,  0,0,0,0,                   0,1,0);
        add(1,0,0,1,0,'h104,0,'h66666666, 1,0,'h104,0,  0,0,0,0,                   0,1,0);
        add(1,0,0,1,0,'h104,0,0,          0,0,0,0,      0,1,0,'h66666666,          0,0,0);
        add(1,0,0,0,0,0,0,0,              0,0,0,0,      0,0,0,'h66666666,          0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n          = vecs[i].rst_n;
            bus0.if_req    = vecs[i].if_req;
            bus0.if_addr   = vecs[i].if_addr;
            bus0.d_req     = vecs[i].d_req;
            bus0.d_we      = vecs[i].d_we;
            bus0.d_addr    = vecs[i].d_addr;
            bus0.d_wdata   = vecs[i].d_wdata;
            bus0.mem_rdata = vecs[i].mem_rdata;
            #3;
            chk1($sformatf("v%0d_mem_en", i), bus0.mem_en, vecs[i].e_en);
            chk1($sformatf("v%0d_mem_we", i), bus0.mem_we, vecs[i].e_we);
            if (vecs[i].e_en || vecs[i].full)
                chk32($sformatf("v%0d_mem_addr", i), bus0.mem_addr, vecs[i].e_addr);
            if (vecs[i].e_we || vecs[i].full)
                chk32($sformatf("v%0d_mem_wdata", i), bus0.mem_wdata, vecs[i].e_wdata);
            chk1($sformatf("v%0d_if_ready", i), bus0.if_ready, vecs[i].e_ifrdy);
            chk1($sformatf("v%0d_d_ready", i), bus0.d_ready, vecs[i].e_drdy);
            chk32($sformatf("v%0d_if_rdata", i), bus0.if_rdata, vecs[i].e_ifrd);
            chk32($sformatf("v%0d_d_rdata", i), bus0.d_rdata, vecs[i].e_drd);
            chk1($sformatf("v%0d_stall_f", i), bus0.stall_f, vecs[i].e_sf);
            chk1($sformatf("v%0d_stall_m", i), bus0.stall_m, vecs[i].e_sm);
        end

        // WAIT_CYCLES=1: single fetch, one busy cycle, ready two cycles after request
        @(posedge clk); #1; bus1_drive(1'b1, 32'h8, 1'b0, '0, '0); #3;
        chk1("w1_req_en", bus1.mem_en, 1'b0);
        chk1("w1_req_stall_f", bus1.stall_f, 1'b1);
        @(posedge clk); #1; bus1_drive(1'b1, 32'h8, 1'b0, '0, 32'h12345678); #3;
        chk1("w1_busy_en", bus1.mem_en, 1'b1);
        chk1("w1_busy_we", bus1.mem_we, 1'b0);
        chk32("w1_busy_addr", bus1.mem_addr, 32'h8);
        chk1("w1_busy_if_ready", bus1.if_ready, 1'b0);
        @(posedge clk); #1; bus1_drive(1'b1, 32'h8, 1'b0, '0, '0); #3;
        chk1("w1_rdy_en", bus1.mem_en, 1'b0);
        chk1("w1_rdy_if_ready", bus1.if_ready, 1'b1);
        chk32("w1_rdy_if_rdata", bus1.if_rdata, 32'h12345678);
        chk1("w1_rdy_stall_f", bus1.stall_f, 1'b0);
        @(posedge clk); #1; bus1_drive(1'b0, '0, 1'b0, '0, '0); #3;
        chk1("w1_idle_en", bus1.mem_en, 1'b0);
        chk1("w1_idle_if_ready", bus1.if_ready, 1'b0);
        chk32("w1_idle_if_rdata", bus1.if_rdata, 32'h12345678);

        // WAIT_CYCLES=1 back-to-back: D wins the tie, I follows in D's ready cycle
        @(posedge clk); #1; bus1_drive(1'b1, 32'h30, 1'b1, 32'h20, '0); #3;
        chk1("w1b_req_en", bus1.mem_en, 1'b0);
        @(posedge clk); #1; bus1_drive(1'b1, 32'h30, 1'b1, 32'h20, 32'hAAAA0001); #3;
        chk1("w1b_d_en", bus1.mem_en, 1'b1);
        chk32("w1b_d_addr", bus1.mem_addr, 32'h20);
        @(posedge clk); #1; bus1_drive(1'b1, 32'h30, 1'b1, 32'h20, '0); #3;
        chk1("w1b_d_ready", bus1.d_ready, 1'b1);
        chk32("w1b_d_rdata", bus1.d_rdata, 32'hAAAA0001);
        chk1("w1b_d_stall_m", bus1.stall_m, 1'b0);
        @(posedge clk); #1; bus1_drive(1'b1, 32'h30, 1'b0, '0, 32'hAAAA0002); #3;
        chk1("w1b_i_en", bus1.mem_en, 1'b1);
        chk32("w1b_i_addr", bus1.mem_addr, 32'h30);
        chk1("w1b_i_d_ready", bus1.d_ready, 1'b0);
        @(posedge clk); #1; bus1_drive(1'b1, 32'h30, 1'b0, '0, '0); #3;
        chk1("w1b_i_ready", bus1.if_ready, 1'b1);
        chk32("w1b_i_rdata", bus1.if_rdata, 32'hAAAA0002);
        chk32("w1b_d_rdata_hold", bus1.d_rdata, 32'hAAAA0001);
        @(posedge clk); #1; bus1_drive(1'b0, '0, 1'b0, '0, '0); #3;
        chk1("w1b_end_en", bus1.mem_en, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
